// File: rtl/count_event_logger_pkg.sv
// Shared types and constants for the count_event_logger block.
// Event kind bit positions, the kind type and the drop counter width.
package count_event_logger_pkg;

    localparam int KIND_OVF = 0;
    localparam int KIND_THR = 1;
    localparam int DROP_W   = 8;

    typedef logic [1:0] kind_t;

endpackage

// File: rtl/count_event_logger_sync_fifo.sv
// Single-clock FIFO with registered storage and wrap-bit pointers.
// Pushes into a full FIFO are taken only when a pop frees a slot on the same edge.
module sync_fifo #(
    parameter  int DW    = 18,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    logic [AW:0]   wr_q, wr_d;
    logic [AW:0]   rd_q, rd_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign level = wr_q - rd_q;
    assign rdata = mem_q[rd_q[AW-1:0]];

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (do_push) begin
            mem_d[wr_q[AW-1:0]] = wdata;
            wr_d                = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Payload needs no reset: it is only visible once the pointers mark it valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/count_event_logger.sv
// Monitors a counter for overflow pulses and threshold crossings, timestamps
// each event and queues it for a valid/ready consumer; overflowing events are counted.
module count_event_logger
    import count_event_logger_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int TS_WIDTH = 16,
    parameter  int DEPTH    = 4,
    localparam int LW       = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    count_in,
    input  logic                overflow_in,
    input  logic [WIDTH-1:0]    threshold_in,
    input  logic                capture_en,
    output logic                event_valid,
    input  logic                event_ready,
    output logic [1:0]          event_kind,
    output logic [TS_WIDTH-1:0] event_ts,
    output logic [DROP_W-1:0]   drop_count,
    output logic [LW-1:0]       fifo_level
);

    localparam int FW = TS_WIDTH + 2;

    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic                hit_q, hit_d;
    logic [DROP_W-1:0]   drop_q, drop_d;

    logic    hit;
    logic    thr_evt;
    logic    ovf_evt;
    kind_t   kind;
    logic    evt;
    logic    pop;
    logic    push;
    logic    drop;
    logic    fifo_full;
    logic    fifo_empty;
    logic [FW-1:0] fifo_rdata;

    assign hit     = (count_in == threshold_in);
    assign thr_evt = hit & ~hit_q;
    assign ovf_evt = overflow_in;

    always_comb begin
        kind           = '0;
        kind[KIND_OVF] = ovf_evt;
        kind[KIND_THR] = thr_evt;
    end

    assign evt  = capture_en & (kind != 2'b00);
    assign pop  = event_valid & event_ready;
    assign push = evt & (~fifo_full | pop);
    assign drop = evt & fifo_full & ~pop;

    // hit_q tracks the compare even while capture is off, so re-enabling
    // on a held match does not manufacture an edge.
    always_comb begin
        ts_d   = ts_q + 1'b1;
        hit_d  = hit;
        drop_d = drop_q;
        if (drop && (drop_q != {DROP_W{1'b1}})) begin
            drop_d = drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q   <= '0;
            hit_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            ts_q   <= ts_d;
            hit_q  <= hit_d;
            drop_q <= drop_d;
        end
    end

    sync_fifo #(
        .DW    (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({kind, ts_q}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign event_valid = ~fifo_empty;
    assign event_kind  = fifo_rdata[FW-1:TS_WIDTH];
    assign event_ts    = fifo_rdata[TS_WIDTH-1:0];
    assign drop_count  = drop_q;

endmodule

// File: tb/tb_count_event_logger.sv
// Directed bench for count_event_logger: a default instance plus a 4-bit
// timestamp instance for the wrap case.
module tb_count_event_logger;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  count_in, threshold_in;
    logic        overflow_in, capture_en, event_ready;
    logic        event_valid;
    logic [1:0]  event_kind;
    logic [15:0] event_ts;
    logic [7:0]  drop_count;
    logic [2:0]  fifo_level;

    logic        rst4;
    logic [7:0]  count4, thr4;
    logic        ovf4, cap4, ready4;
    logic        valid4;
    logic [1:0]  kind4;
    logic [3:0]  ts4;
    logic [7:0]  drop4;
    logic [2:0]  level4;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    // Cycles since reset release: equals the logger's timestamp at the sample point.
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    count_event_logger u_dut (
        .clk          (clk),
        .rst          (rst),
        .count_in     (count_in),
        .overflow_in  (overflow_in),
        .threshold_in (threshold_in),
        .capture_en   (capture_en),
        .event_valid  (event_valid),
        .event_ready  (event_ready),
        .event_kind   (event_kind),
        .event_ts     (event_ts),
        .drop_count   (drop_count),
        .fifo_level   (fifo_level)
    );

    count_event_logger #(.TS_WIDTH(4)) u_dut4 (
        .clk          (clk),
        .rst          (rst4),
        .count_in     (count4),
        .overflow_in  (ovf4),
        .threshold_in (thr4),
        .capture_en   (cap4),
        .event_valid  (valid4),
        .event_ready  (ready4),
        .event_kind   (kind4),
        .event_ts     (ts4),
        .drop_count   (drop4),
        .fifo_level   (level4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; overflow_in = 1'b1; capture_en = 1'b1; event_ready = 1'b0;
        count_in = 8'd0; threshold_in = 8'd100;
        tick(); tick();
        n_chk++; if (event_valid !== 1'b0) $display("FAIL rst_valid got %0b want 0", event_valid); else n_pass++;
        n_chk++; if (fifo_level !== 3'd0) $display("FAIL rst_level got %0d want 0", fifo_level); else n_pass++;
        n_chk++; if (drop_count !== 8'd0) $display("FAIL rst_drop got %0d want 0", drop_count); else n_pass++;
        rst = 1'b0; overflow_in = 1'b0;
        tick();
        n_chk++; if (event_valid !== 1'b0) $display("FAIL rst_idle_valid got %0b want 0", event_valid); else n_pass++;
    endtask

    task automatic test_threshold();
        logic [15:0] exp_ts;
        event_ready = 1'b1;
        count_in = 8'd98; tick();
        count_in = 8'd99; tick();
        count_in = 8'd100; exp_ts = cyc[15:0];
        tick();
        n_chk++; if (event_valid !== 1'b1) $display("FAIL thr_valid got %0b want 1", event_valid); else n_pass++;
        n_chk++; if (event_kind !== 2'b10) $display("FAIL thr_kind got %b want 10", event_kind); else n_pass++;
        n_chk++; if (event_ts !== exp_ts) $display("FAIL thr_ts got %0d want %0d", event_ts, exp_ts); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++; if (event_valid !== 1'b0) $display("FAIL thr_hold_%0d got valid %0b want 0", i, event_valid); else n_pass++;
        end
        count_in = 8'd101; tick();
    endtask

    task automatic test_ovf_and_thr();
        logic [15:0] exp_ts;
        threshold_in = 8'd0;
        for (int c = 250; c < 256; c++) begin
            count_in = 8'(c); tick();
        end
        n_chk++; if (event_valid !== 1'b0) $display("FAIL both_pre got valid %0b want 0", event_valid); else n_pass++;
        count_in = 8'd0; overflow_in = 1'b1; exp_ts = cyc[15:0];
        tick();
        n_chk++; if (event_valid !== 1'b1) $display("FAIL both_valid got %0b want 1", event_valid); else n_pass++;
        n_chk++; if (event_kind !== 2'b11) $display("FAIL both_kind got %b want 11", event_kind); else n_pass++;
        n_chk++; if (event_ts !== exp_ts) $display("FAIL both_ts got %0d want %0d", event_ts, exp_ts); else n_pass++;
        count_in = 8'd1; overflow_in = 1'b0;
        tick();
        n_chk++; if (event_valid !== 1'b0) $display("FAIL both_after got valid %0b want 0", event_valid); else n_pass++;
        threshold_in = 8'd100;
        tick();
    endtask

    task automatic test_full_drop_and_pushpop();
        logic [15:0] e [0:6];
        event_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            overflow_in = 1'b1; e[i] = cyc[15:0]; tick();
        end
        overflow_in = 1'b0;
        n_chk++; if (fifo_level !== 3'd4) $display("FAIL full_level got %0d want 4", fifo_level); else n_pass++;
        n_chk++; if (drop_count !== 8'd2) $display("FAIL full_drop got %0d want 2", drop_count); else n_pass++;
        n_chk++; if (event_ts !== e[0]) $display("FAIL full_head_ts got %0d want %0d", event_ts, e[0]); else n_pass++;
        n_chk++; if (event_kind !== 2'b01) $display("FAIL full_head_kind got %b want 01", event_kind); else n_pass++;
        // Push and pop on the same edge while full.
        event_ready = 1'b1; overflow_in = 1'b1; e[6] = cyc[15:0];
        tick();
        overflow_in = 1'b0;
        n_chk++; if (fifo_level !== 3'd4) $display("FAIL pushpop_level got %0d want 4", fifo_level); else n_pass++;
        n_chk++; if (drop_count !== 8'd2) $display("FAIL pushpop_drop got %0d want 2", drop_count); else n_pass++;
        for (int i = 1; i < 4; i++) begin
            n_chk++; if (event_ts !== e[i]) $display("FAIL drain_ts_%0d got %0d want %0d", i, event_ts, e[i]); else n_pass++;
            tick();
        end
        n_chk++; if (event_ts !== e[6]) $display("FAIL drain_ts_last got %0d want %0d", event_ts, e[6]); else n_pass++;
        tick();
        n_chk++; if (event_valid !== 1'b0) $display("FAIL drain_empty got valid %0b want 0", event_valid); else n_pass++;
        n_chk++; if (fifo_level !== 3'd0) $display("FAIL drain_level got %0d want 0", fifo_level); else n_pass++;
    endtask

    task automatic test_drop_saturate();
        event_ready = 1'b0; overflow_in = 1'b1;
        repeat (262) tick();
        overflow_in = 1'b0;
        n_chk++; if (drop_count !== 8'd255) $display("FAIL sat_drop got %0d want 255", drop_count); else n_pass++;
        rst = 1'b1; tick(); rst = 1'b0;
        n_chk++; if (drop_count !== 8'd0) $display("FAIL sat_clear got %0d want 0", drop_count); else n_pass++;
    endtask

    task automatic test_reset_midop();
        event_ready = 1'b0; overflow_in = 1'b1;
        repeat (3) tick();
        overflow_in = 1'b0;
        n_chk++; if (fifo_level !== 3'd3) $display("FAIL midop_level got %0d want 3", fifo_level); else n_pass++;
        rst = 1'b1; overflow_in = 1'b1;
        tick();
        rst = 1'b0; overflow_in = 1'b0;
        n_chk++; if (event_valid !== 1'b0) $display("FAIL midop_valid got %0b want 0", event_valid); else n_pass++;
        n_chk++; if (fifo_level !== 3'd0) $display("FAIL midop_flush got %0d want 0", fifo_level); else n_pass++;
    endtask

    task automatic test_capture_en();
        event_ready = 1'b1; capture_en = 1'b0;
        count_in = 8'd100; overflow_in = 1'b1;
        repeat (3) tick();
        n_chk++; if (event_valid !== 1'b0) $display("FAIL capoff_valid got %0b want 0", event_valid); else n_pass++;
        overflow_in = 1'b0; capture_en = 1'b1;
        tick();
        n_chk++; if (event_valid !== 1'b0) $display("FAIL reenable_valid got %0b want 0", event_valid); else n_pass++;
        count_in = 8'd1; tick();
        count_in = 8'd100; tick();
        n_chk++; if (event_kind !== 2'b10 || event_valid !== 1'b1)
            $display("FAIL recapture got valid %0b kind %b want 1 10", event_valid, event_kind); else n_pass++;
        count_in = 8'd1; tick();
    endtask

    task automatic test_ts_wrap();
        rst4 = 1'b1; tick(); rst4 = 1'b0;
        repeat (15) tick();
        ovf4 = 1'b1; tick(); tick(); ovf4 = 1'b0;
        n_chk++; if (level4 !== 3'd2) $display("FAIL wrap_level got %0d want 2", level4); else n_pass++;
        n_chk++; if (ts4 !== 4'd15) $display("FAIL wrap_ts_first got %0d want 15", ts4); else n_pass++;
        n_chk++; if (kind4 !== 2'b01) $display("FAIL wrap_kind got %b want 01", kind4); else n_pass++;
        ready4 = 1'b1; tick(); ready4 = 1'b0;
        n_chk++; if (ts4 !== 4'd0 || valid4 !== 1'b1) $display("FAIL wrap_ts_second got %0d valid %0b want 0 1", ts4, valid4); else n_pass++;
        n_chk++; if (drop4 !== 8'd0) $display("FAIL wrap_drop got %0d want 0", drop4); else n_pass++;
    endtask

    initial begin
        rst4 = 1'b1; count4 = 8'd1; thr4 = 8'd0; ovf4 = 1'b0; cap4 = 1'b1; ready4 = 1'b0;
        test_reset();
        test_threshold();
        test_ovf_and_thr();
        test_full_drop_and_pushpop();
        test_drop_saturate();
        test_reset_midop();
        test_capture_en();
        test_ts_wrap();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/count_event_logger.md
# count_event_logger

Downstream monitor for the `counter` block. It samples the counter's `count` and `overflow` outputs every cycle and detects overflow pulses and threshold-crossing events. Each detected event is tagged with a free-running timestamp and queued in a small FIFO. A valid/ready consumer (scoreboard, coverage collector or register interface) drains the FIFO; events that arrive while the FIFO is full are counted and discarded.

## Interface
- `WIDTH`, 8: width of `count_in` and `threshold_in`; matches `counter.WIDTH`.
- `TS_WIDTH`, 16: timestamp width.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.

Ports (clock and reset first):
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `count_in`  in  WIDTH  counter value.
- `overflow_in`  in  1  counter overflow flag.
- `threshold_in`  in  WIDTH  match value; quasi-static.
- `capture_en`  in  1  when 0, no events are captured; timestamp still runs.
- `event_valid`  out  1  FIFO head is valid.
- `event_ready`  in  1  consumer accepts the head.
- `event_kind`  out  2  bit0 = overflow, bit1 = threshold hit.
- `event_ts`  out  TS_WIDTH  timestamp of the head entry.
- `drop_count`  out  8  saturating count of dropped events.
- `fifo_level`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- **Timestamp:**
  - `ts_q` increments by 1 every cycle.
  - Wraps from 2^TS_WIDTH−1 to 0 with no flag.
- **Match detect:**
  - `hit = (count_in == threshold_in)`; `hit_q` is its one-cycle-delayed register.
  - Threshold event fires on `hit & ~hit_q` (rising edge only). A count that holds at the threshold yields one event.
- **Overflow event:** fires on every cycle that `overflow_in` = 1. It is level-per-cycle, not edge-detected.
- **Combining:**
  - `kind = {thr_evt, ovf_evt}`.
  - If `capture_en` = 1 and `kind` ≠ 0, one push of `{kind, ts_q}` occurs in that cycle.
  - Simultaneous overflow and threshold events produce one entry with kind = 2'b11.
- **Pop:** occurs when `event_valid & event_ready`.
- **Full:**
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the event is dropped and `drop_count` increments, saturating at 255.
- **Empty with simultaneous push:** the entry is written and no pop occurs. `event_valid` was 0, so no bypass is possible.
- **capture_en = 0:** `hit_q` still updates, so re-enabling while the count sits at the threshold generates no event.
- **Outputs:** `event_kind` and `event_ts` are stable while `event_valid` = 1 and `event_ready` = 0. Their values are don't-care when `event_valid` = 0.

## Timing
- **Reset values:**
  - `event_valid` = 0, `fifo_level` = 0, `drop_count` = 0.
  - `ts_q` = 0, `hit_q` = 0. Because `hit_q` resets to 0, a match in the first cycle after reset is an event.
- **Reset mid-operation:** flushes all entries and clears all counters on the next edge. Inputs during the reset cycle are ignored.
- **Latency:**
  - An event sampled at edge N is written at edge N.
  - If the FIFO was empty, `event_valid` = 1 after edge N and `event_ts` = `ts_q` before edge N.
- **Throughput:** one push and one pop per cycle sustained.
- **Consumer rule:** `event_ready` may be held high continuously. Valid never depends combinationally on ready.
- **Level update:** `fifo_level` updates on the same edge as the push or pop.

## Structure
- **Package `count_event_logger_pkg`:**
  - `KIND_OVF` = 0 and `KIND_THR` = 1 (bit indices).
  - `kind_t` = logic [1:0].
  - `DROP_W` = 8.
- **Sub-module `sync_fifo`:**
  - Parameters: data width and DEPTH.
  - Implementation: registered storage with read/write pointers carrying an extra wrap bit.
  - Ports: `full`, `empty` and `level`.
- **Top level:** holds the timestamp counter, the edge detector, the push/drop logic and the drop counter.

## Test plan
- **Reset:** hold `rst` for 2 cycles with `overflow_in` = 1 → no events; all outputs are at their reset values.
- **Threshold hit:**
  - Setup: `threshold_in` = 100, counter loaded to 98 and enabled, `event_ready` = 1.
  - Required: exactly one event with kind = 2'b10, and its `ts` equals the cycle on which count = 100.
  - Holding count at 100 produces no further events.
- **Overflow and threshold together:**
  - Setup: `threshold_in` = 0, counter loaded to 250 and enabled.
  - Required: at the wrap, one entry with kind = 2'b11.
- **Full and drop:**
  - Setup: `event_ready` = 0 and 6 overflow pulses with DEPTH = 4.
  - Required: `fifo_level` = 4 and `drop_count` = 2.
  - Then raise `event_ready` → the 4 entries drain in order with increasing `ts`.
- **Push and pop while full:** while full, push and pop in the same cycle → level stays at 4 and `drop_count` is unchanged.
- **Timestamp wrap and reset:**
  - With TS_WIDTH = 4, events straddling the wrap carry ts = 15 then ts = 0.
  - Asserting `rst` while 3 entries are queued → `event_valid` = 0 on the next cycle.
